uart_tx_brg: RTL and testbench

//  UART transmit path with an integrated baud-rate generator (BRG) for the SPART-style I/O bus.
//  The CPU writes a byte at ioaddr 00; the block serialises it on txd as an 8N1 frame, LSB first.
//  The BRG divides clk into a 16x-oversample tick (brg_full) that paces each bit.
//  The divisor is programmable through ioaddr 10/11 and defaults to 4800 baud at 50 MHz.

---
 rtl/uart_tx_brg.sv | 105 ++++++++++
 tb/tb_uart_tx_brg.sv | 147 ++++++++++++++
 2 files changed

// File: rtl/uart_tx_brg.sv
// UART 8N1 transmitter with a programmable 16x baud-rate generator on the SPART I/O bus.
// A byte written at ioaddr 00 while tbr=1 is shifted out LSB first on txd.
module uart_tx_brg #(
  parameter logic [15:0] DEFAULT_DIV = 16'd650,
  parameter int unsigned OVERSAMPLE  = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       iorw,
  input  logic       iocs,
  input  logic [1:0] ioaddr,
  input  logic [7:0] databus,
  output logic       tbr,
  output logic       txd
);

  localparam int unsigned TickW = $clog2(OVERSAMPLE);
  localparam logic [TickW-1:0] TickLast = TickW'(OVERSAMPLE - 1);

  typedef enum logic [1:0] {StIdle, StStart, StData, StStop} state_e;

  state_e           state_q, state_d;
  logic [15:0]      div_q;
  logic [15:0]      baud_q;
  logic [TickW-1:0] tick_q;
  logic [7:0]       shift_q, shift_d;
  logic [2:0]       bit_q, bit_d;

  logic wr_strobe;
  logic accept;
  logic brg_full;
  logic bit_done;

  assign wr_strobe = iocs & ~iorw;
  assign accept    = wr_strobe && (ioaddr == 2'b00) && (state_q == StIdle);
  assign brg_full  = (baud_q == 16'd0);
  assign bit_done  = brg_full && (tick_q == TickLast);

  // Accept restarts the BRG phase so the start bit gets a full 16 ticks.
  always_ff @(posedge clk) begin
    if (rst) begin
      div_q   <= DEFAULT_DIV;
      baud_q  <= DEFAULT_DIV;
      tick_q  <= '0;
      state_q <= StIdle;
      shift_q <= 8'd0;
      bit_q   <= 3'd0;
    end else begin
      if (wr_strobe && (ioaddr == 2'b10)) div_q[7:0]  <= databus;
      if (wr_strobe && (ioaddr == 2'b11)) div_q[15:8] <= databus;

      if (accept || brg_full) baud_q <= div_q;
      else                    baud_q <= baud_q - 16'd1;

      if (accept)                   tick_q <= '0;
      else if (bit_done)            tick_q <= '0;
      else if (brg_full)            tick_q <= tick_q + 1'b1;

      state_q <= state_d;
      shift_q <= shift_d;
      bit_q   <= bit_d;
    end
  end

  always_comb begin
    state_d = state_q;
    shift_d = shift_q;
    bit_d   = bit_q;
    unique case (state_q)
      StIdle: begin
        if (accept) begin
          shift_d = databus;
          bit_d   = 3'd0;
          state_d = StStart;
        end
      end
      StStart: begin
        if (bit_done) state_d = StData;
      end
      StData: begin
        if (bit_done) begin
          shift_d = {1'b0, shift_q[7:1]};
          bit_d   = bit_q + 3'd1;
          if (bit_q == 3'd7) state_d = StStop;
        end
      end
      StStop: begin
        if (bit_done) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    txd = 1'b1;
    unique case (state_q)
      StStart: txd = 1'b0;
      StData:  txd = shift_q[0];
      default: txd = 1'b1;
    endcase
  end

  assign tbr = (state_q == StIdle);

endmodule

// File: tb/tb_uart_tx_brg.sv
// Directed bench for uart_tx_brg: frame shape and timing, ignored writes, divisor programming, reset.
// A small default divisor keeps each frame short; bit time = 16*(DIV+1) cycles.
module tb_uart_tx_brg;

  localparam logic [15:0] TbDiv = 16'd15;
  localparam int BitDef = 16 * (TbDiv + 1);

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       iorw = 1'b0;
  logic       iocs = 1'b0;
  logic [1:0] ioaddr = 2'b00;
  logic [7:0] databus = 8'h00;
  logic       tbr;
  logic       txd;

  int cyc = 0;
  int n_chk = 0;
  int n_bad = 0;

  uart_tx_brg #(
    .DEFAULT_DIV(TbDiv),
    .OVERSAMPLE (16)
  ) dut (
    .clk    (clk),
    .rst    (rst),
    .iorw   (iorw),
    .iocs   (iocs),
    .ioaddr (ioaddr),
    .databus(databus),
    .tbr    (tbr),
    .txd    (txd)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // One-cycle bus access; returns #1 after the edge that samples it.
  task automatic bus_access(input logic [1:0] a, input logic [7:0] d, input logic cs,
                            input logic rw);
    ioaddr  = a;
    databus = d;
    iocs    = cs;
    iorw    = rw;
    step();
    iocs = 1'b0;
    iorw = 1'b0;
  endtask

  // Sends a byte and checks the first and last cycle of every bit plus the tbr rise time.
  // inj > 0 issues a 0x55 write at that cycle offset into the frame.
  task automatic send_frame(input logic [7:0] data, input int bt, input int inj, input string nm);
    logic [9:0] fr;
    int         e;
    fr = {1'b1, data, 1'b0};
    bus_access(2'b00, data, 1'b1, 1'b0);
    e = cyc;
    check_eq({nm, " tbr low on accept"}, {31'd0, tbr}, 32'd0);
    for (int t = 0; t < 10 * bt; t++) begin
      if (t > 0) step();
      if (inj > 0 && t == inj) begin
        ioaddr = 2'b00; databus = 8'h55; iocs = 1'b1; iorw = 1'b0;
      end else begin
        iocs = 1'b0;
      end
      if (t % bt == 0 || t % bt == bt - 1)
        check_eq($sformatf("%s bit%0d t%0d txd", nm, t / bt, t % bt), {31'd0, txd},
                 {31'd0, fr[t / bt]});
    end
    iocs = 1'b0;
    check_eq({nm, " tbr low last cycle"}, {31'd0, tbr}, 32'd0);
    step();
    check_eq({nm, " frame length"}, cyc - e, 10 * bt);
    check_eq({nm, " tbr high at end"}, {31'd0, tbr}, 32'd1);
    check_eq({nm, " txd idle at end"}, {31'd0, txd}, 32'd1);
  endtask

  task automatic idle_quiet(input int n, input string nm);
    int lows;
    int busy;
    lows = 0;
    busy = 0;
    for (int i = 0; i < n; i++) begin
      step();
      if (txd !== 1'b1) lows++;
      if (tbr !== 1'b1) busy++;
    end
    check_eq({nm, " txd low cycles"}, lows, 0);
    check_eq({nm, " tbr busy cycles"}, busy, 0);
  endtask

  initial begin
    step();
    step();
    rst = 1'b0;
    check_eq("reset txd", {31'd0, txd}, 32'd1);
    check_eq("reset tbr", {31'd0, tbr}, 32'd1);
    idle_quiet(1000, "post-reset idle");

    send_frame(8'h7B, BitDef, 0, "f7B");
    idle_quiet(300, "gap");
    send_frame(8'hAA, BitDef, 3 * BitDef + 5, "fAA");
    idle_quiet(50, "after ignored write");

    // Non-strobes: iocs low, read cycle, and address 01.
    bus_access(2'b00, 8'h00, 1'b0, 1'b0);
    bus_access(2'b00, 8'h00, 1'b1, 1'b1);
    bus_access(2'b01, 8'h00, 1'b1, 1'b0);
    idle_quiet(20, "non-strobe");

    bus_access(2'b11, 8'h00, 1'b1, 1'b0);
    bus_access(2'b10, 8'h03, 1'b1, 1'b0);
    step();
    send_frame(8'h01, 64, 0, "div3");
    // Back-to-back: write on the cycle right after tbr rises.
    send_frame(8'h80, 64, 0, "b2b");

    // Reset during d3, then the default divisor must be back.
    bus_access(2'b00, 8'h7B, 1'b1, 1'b0);
    repeat (4 * 64 + 10) step();
    check_eq("pre-reset tbr busy", {31'd0, tbr}, 32'd0);
    rst = 1'b1;
    step();
    rst = 1'b0;
    check_eq("midframe reset txd", {31'd0, txd}, 32'd1);
    check_eq("midframe reset tbr", {31'd0, tbr}, 32'd1);
    idle_quiet(20, "post midframe reset");
    send_frame(8'h01, BitDef, 0, "default div");

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

endmodule
